// File: rtl/instr_encoder.sv
// Instruction encoder: packs symbolic instruction requests into 32-bit MIPS
// words, queues them in a small FIFO and streams them out with word addresses.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_JR   = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_JAL);
  endfunction

  // Fields an op does not use are simply left out of its word.
  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0;
    case (op)
      OP_ADD:  w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      OP_SUB:  w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      OP_AND:  w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      OP_OR:   w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      OP_SLT:  w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      OP_JR:   w = {6'h00, rs, 15'd0, 6'h08};
      OP_BNE:  w = {6'h05, rs, rt, imm};
      OP_LW:   w = {6'h23, rs, rt, imm};
      OP_SW:   w = {6'h2B, rs, rt, imm};
      OP_ADDI: w = {6'h08, rs, rt, imm};
      OP_JAL:  w = {6'h03, target};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  logic [31:0]       mem_q [DEPTH];
  logic [PW:0]       wr_q, wr_d;
  logic [PW:0]       rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic              full, empty;
  logic              accept, push, pop;
  logic [31:0]       enc_word;

  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty = (wr_q == rd_q);

  // No pop credit: a full FIFO refuses input even in a cycle it drains.
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal(in_op);
  assign pop      = out_valid && out_ready;
  assign enc_word = encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d   = rd_q + 1'b1;
      addr_d = addr_q + WORD_STEP;
      if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
    end
    // A clear in the same cycle as a pop overrides the increment.
    if (addr_clr) addr_d = BASE;
    if (accept && !is_legal(in_op)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      addr_q <= BASE;
      wcnt_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  // Storage carries no reset; emptiness is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= enc_word;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? 32'h0 : mem_q[rd_q[PW-1:0]];
  assign out_addr   = addr_q;
  assign err        = err_q;
  assign word_count = wcnt_q;

endmodule
